hit_frame_packer: RTL and testbench
===================================

Name: hit_frame_packer

Overview:
- Downstream consumer of the 128-pixel array top (pixel cells plus 128-to-7 priority encoder).
- Drives the encoder's read strobe and drains every latched hit address, one per cycle.
- Wraps each frame's hits as header word, hit words, trailer word in a 16-bit stream.
- Buffers the stream in a FIFO and presents it to the serializer/link through a valid/ready interface.

Parameters:
- DEPTH, 16, FIFO depth in words (power of 2, ≥4).
- FRAME_W, 14, frame counter width (≤14).
- MAX_HITS, 128, hit words per frame before a forced trailer.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse that opens a readout frame.
- enc_valid  in  1  encoder has a pending hit (combinational from pixel state).
- enc_addr  in  7  address of the highest-priority pending hit.
- enc_read  out  1  read strobe; hit is consumed and its pixel cleared at the clock edge.
- out_data  out  16  FIFO head word.
- out_valid  out  1  FIFO not empty.
- out_ready  in  1  sink accepts out_data this cycle.
- frame_cnt  out  FRAME_W  number of the current/last frame.
- overflow  out  1  sticky: a frame was truncated at MAX_HITS.
- missed_frame  out  1  sticky: frame_start arrived while not IDLE.

Behaviour:
- Word format:
  - Header: [15:14]=2'b10, [13:0]=frame number (zero-extended).
  - Hit: [15:14]=2'b00, [13:7]=0, [6:0]=addr.
  - Trailer: [15:14]=2'b11, [13:8]=0, [7:0]=hit count, where 128 encodes as 8'h80.
- Reset: state IDLE, FIFO empty, out_valid=0, out_data=0, enc_read=0, frame_cnt=0, overflow=0, missed_frame=0, hit count=0. Reset mid-frame aborts the frame and discards FIFO contents; the encoder is not read.
- Handshake: a hit transfers only on an edge where enc_read=1 && enc_valid=1.
  - enc_read is registered-state combinational: high only in SCAN && fifo not full && hit count < MAX_HITS.
  - enc_read may be high while enc_valid=0; nothing transfers.
- FSM:
  - IDLE: on frame_start → HEADER; the same edge increments frame_cnt (wraps at 2^FRAME_W), and the header carries the incremented value.
  - HEADER: push header when not full, then → SCAN; if full, stall.
  - SCAN: each cycle with enc_read && enc_valid pushes a hit word and increments hit count.
    - → TRAILER when enc_valid=0 while not full. A hit arriving later belongs to the next frame.
    - → TRAILER when hit count reaches MAX_HITS; set overflow only if enc_valid is still 1 at that point.
  - TRAILER: push trailer when not full, clear hit count, → IDLE.
- frame_start in any state other than IDLE is ignored and sets missed_frame. frame_cnt is unchanged.
- FIFO:
  - Push only when count < DEPTH; pop when out_valid && out_ready.
  - Simultaneous push and pop keeps count unchanged, including when full (pop frees the slot the same edge).
  - out_data is the head word, valid the same cycle as out_valid.
  - Latency: a hit accepted at edge N is visible at out_data after edge N if the FIFO was empty.
  - out_ready while empty has no effect; pointers wrap modulo DEPTH.
- Throughput: 1 word/cycle in and out; frame overhead is 2 cycles (header, trailer) plus one cycle to detect enc_valid=0.

Decomposition:
- Package hit_pkg: word-type constants (HDR=2'b10, HIT=2'b00, TRL=2'b11), word width 16, address width 7, FSM state encoding.
- One sub-module, sync_fifo (params WIDTH, DEPTH; push/pop/full/empty/count). The FSM, counters and word muxing stay in hit_frame_packer.

Test Plan:
- Empty frame: frame_start with enc_valid=0, out_ready=1 → stream is 16'h8001, then 16'hC000; frame_cnt=1; enc_read never transfers.
- Three hits: addrs 5, 64, 127, each deasserting after its read edge → 16'h8001, 16'h0005, 16'h0040, 16'h007F, 16'hC003; exactly 3 transfer edges.
- Backpressure: out_ready=0, 20 pending hits, DEPTH=16 → enc_read drops once the FIFO holds 16 words with no word lost. Then out_ready=1 → all 20 hits plus header and trailer arrive in order; trailer is 16'hC014.
- Truncation: enc_valid held 1 for 200 cycles → exactly 128 hit words, trailer 16'hC080, overflow=1 and stays set until reset.
- frame_start during SCAN → ignored, missed_frame=1, frame_cnt unchanged; the next frame_start in IDLE yields header frame+1.
- Reset asserted mid-SCAN with the FIFO holding 5 words → next cycle out_valid=0, enc_read=0, frame_cnt=0, flags clear; the next frame's header is 16'h8001.

Source files
------------

// File: rtl/hit_pkg.sv
// Shared constants, FSM state type and word builders for the hit frame packer.
package hit_pkg;

  localparam int unsigned WORD_W = 16;
  localparam int unsigned ADDR_W = 7;
  localparam int unsigned HCNT_W = 8;
  localparam int unsigned FNUM_W = 14;

  // Word-type tags carried in bits [15:14].
  localparam logic [1:0] HDR = 2'b10;
  localparam logic [1:0] HIT = 2'b00;
  localparam logic [1:0] TRL = 2'b11;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHeader  = 2'd1,
    StScan    = 2'd2,
    StTrailer = 2'd3
  } state_e;

  function automatic logic [WORD_W-1:0] mk_header(input logic [FNUM_W-1:0] frame);
    return {HDR, frame};
  endfunction

  function automatic logic [WORD_W-1:0] mk_hit(input logic [ADDR_W-1:0] addr);
    return {HIT, 7'b0, addr};
  endfunction

  // A full frame of 128 hits encodes naturally as 8'h80.
  function automatic logic [WORD_W-1:0] mk_trailer(input logic [HCNT_W-1:0] cnt);
    return {TRL, 6'b0, cnt};
  endfunction

endpackage

// File: rtl/hit_frame_packer_if.sv
// Encoder read handshake plus valid/ready output stream of the hit frame packer.
interface hit_frame_packer_if;
  import hit_pkg::*;

  logic              enc_valid;
  logic [ADDR_W-1:0] enc_addr;
  logic              enc_read;
  logic [WORD_W-1:0] out_data;
  logic              out_valid;
  logic              out_ready;

  // Packer side.
  modport slave (
    input  enc_valid,
    input  enc_addr,
    input  out_ready,
    output enc_read,
    output out_data,
    output out_valid
  );

  // Environment side: encoder and downstream sink.
  modport master (
    output enc_valid,
    output enc_addr,
    output out_ready,
    input  enc_read,
    input  out_data,
    input  out_valid
  );

endinterface

// File: rtl/hit_frame_packer_sync_fifo.sv
// Single-clock FIFO; head word shown combinationally, zero while empty.
module sync_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wdata,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rdata,
  output logic                     o_full,
  output logic                     o_empty,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int unsigned AW     = $clog2(DEPTH);
  localparam int unsigned CountW = AW + 1;

  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [CountW-1:0] r_count;
  logic              w_pop_ok;
  logic              w_push_ok;

  assign o_full   = (r_count == CountW'(DEPTH));
  assign o_empty  = (r_count == '0);
  assign o_count  = r_count;
  assign w_pop_ok = i_pop && !o_empty;
  // A pop frees its slot on the same edge, so a full FIFO can still take a word.
  assign w_push_ok = i_push && (!o_full || w_pop_ok);
  assign o_rdata   = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents need no reset since pointers gate visibility.
  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy update; pointers wrap modulo DEPTH.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop_ok) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/hit_frame_packer.sv
// Drains the pixel-array priority encoder once per frame and emits
// header / hit words / trailer through a FIFO to a valid/ready sink.
module hit_frame_packer
  import hit_pkg::*;
#(
  parameter int unsigned DEPTH    = 16,
  parameter int unsigned FRAME_W  = 14,
  parameter int unsigned MAX_HITS = 128
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_frame_start,
  hit_frame_packer_if.slave  bus,
  output logic [FRAME_W-1:0] o_frame_cnt,
  output logic               o_overflow,
  output logic               o_missed_frame
);

  localparam logic [HCNT_W-1:0] MaxCnt = HCNT_W'(MAX_HITS);

  state_e              r_state;
  state_e              w_state_nxt;
  logic [FRAME_W-1:0]  r_frame_cnt;
  logic [FRAME_W-1:0]  w_frame_cnt_nxt;
  logic [HCNT_W-1:0]   r_hit_cnt;
  logic [HCNT_W-1:0]   w_hit_cnt_nxt;
  logic                r_overflow;
  logic                w_overflow_nxt;
  logic                r_missed;
  logic                w_missed_nxt;

  logic                w_push;
  logic [WORD_W-1:0]   w_push_data;
  logic                w_pop;
  logic                w_full;
  logic                w_empty;
  logic [WORD_W-1:0]   w_head;
  logic [$clog2(DEPTH):0] w_fifo_cnt;
  logic                w_unused_cnt;

  logic                w_hit_room;
  logic                w_enc_read;
  logic                w_hit_xfer;

  assign w_hit_room = (r_hit_cnt < MaxCnt);
  // Held low during reset so an aborted frame never clears a pixel.
  assign w_enc_read = !reset && (r_state == StScan) && !w_full && w_hit_room;
  assign w_hit_xfer = w_enc_read && bus.enc_valid;
  assign w_pop      = !w_empty && bus.out_ready;

  assign bus.enc_read  = w_enc_read;
  assign bus.out_valid = !w_empty;
  assign bus.out_data  = w_head;

  assign o_frame_cnt    = r_frame_cnt;
  assign o_overflow     = r_overflow;
  assign o_missed_frame = r_missed;

  // Occupancy is reported by the FIFO but only full/empty drive decisions here.
  assign w_unused_cnt = ^w_fifo_cnt;

  // Next-state, counters, sticky flags and the word to push this cycle.
  always_comb begin
    w_state_nxt     = r_state;
    w_frame_cnt_nxt = r_frame_cnt;
    w_hit_cnt_nxt   = r_hit_cnt;
    w_overflow_nxt  = r_overflow;
    w_missed_nxt    = r_missed;
    w_push          = 1'b0;
    w_push_data     = '0;

    if (i_frame_start && (r_state != StIdle)) begin
      w_missed_nxt = 1'b1;
    end

    unique case (r_state)
      StIdle: begin
        if (i_frame_start) begin
          w_state_nxt     = StHeader;
          w_frame_cnt_nxt = r_frame_cnt + 1'b1;
        end
      end
      StHeader: begin
        if (!w_full) begin
          w_push      = 1'b1;
          w_push_data = mk_header(FNUM_W'(r_frame_cnt));
          w_state_nxt = StScan;
        end
      end
      StScan: begin
        if (!w_hit_room) begin
          // Frame is truncated only if a hit is still waiting.
          w_state_nxt = StTrailer;
          if (bus.enc_valid) begin
            w_overflow_nxt = 1'b1;
          end
        end else if (w_hit_xfer) begin
          w_push        = 1'b1;
          w_push_data   = mk_hit(bus.enc_addr);
          w_hit_cnt_nxt = r_hit_cnt + 1'b1;
        end else if (!w_full && !bus.enc_valid) begin
          // Encoder drained; later hits belong to the next frame.
          w_state_nxt = StTrailer;
        end
      end
      StTrailer: begin
        if (!w_full) begin
          w_push        = 1'b1;
          w_push_data   = mk_trailer(r_hit_cnt);
          w_hit_cnt_nxt = '0;
          w_state_nxt   = StIdle;
        end
      end
      default: begin
        w_state_nxt = StIdle;
      end
    endcase
  end

  // State and counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StIdle;
      r_frame_cnt <= '0;
      r_hit_cnt   <= '0;
      r_overflow  <= 1'b0;
      r_missed    <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_frame_cnt <= w_frame_cnt_nxt;
      r_hit_cnt   <= w_hit_cnt_nxt;
      r_overflow  <= w_overflow_nxt;
      r_missed    <= w_missed_nxt;
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (w_push_data),
    .i_pop   (w_pop),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_fifo_cnt)
  );

endmodule

// File: tb/tb_hit_frame_packer.sv
// Bench for hit_frame_packer: a queue of pending hits stands in for the
// encoder, and each accepted frame is turned into its expected word list.
module tb_hit_frame_packer;

  localparam int unsigned DEPTH    = 16;
  localparam int unsigned FRAME_W  = 14;
  localparam int unsigned MAX_HITS = 128;

  logic               clk = 1'b0;
  logic               reset;
  logic               frame_start;
  logic [FRAME_W-1:0] frame_cnt;
  logic               overflow;
  logic               missed_frame;

  hit_frame_packer_if u_if ();

  hit_frame_packer #(
    .DEPTH    (DEPTH),
    .FRAME_W  (FRAME_W),
    .MAX_HITS (MAX_HITS)
  ) u_dut (
    .clk            (clk),
    .reset          (reset),
    .i_frame_start  (frame_start),
    .bus            (u_if),
    .o_frame_cnt    (frame_cnt),
    .o_overflow     (overflow),
    .o_missed_frame (missed_frame)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  logic [6:0]  pending[$];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int          xfer_cnt = 0;
  logic [13:0] m_frame = '0;
  logic        m_missed = 1'b0;
  logic        m_over = 1'b0;
  int          rdy_pct = 100;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %h, want %h", name, act, req);
    end
  endfunction

  function automatic logic [15:0] got_at(input int i);
    if (i >= 0 && i < got_q.size()) return got_q[i];
    return 'x;
  endfunction

  // Per-cycle compare against the model, sampled mid-cycle.
  always @(negedge clk) begin
    if (reset) begin
      chk("enc_read_in_reset", {31'b0, u_if.enc_read}, 32'd0);
    end else begin
      chk("frame_cnt", {18'b0, frame_cnt}, {18'b0, m_frame});
      chk("missed_frame", {31'b0, missed_frame}, {31'b0, m_missed});
      if (!m_over) chk("overflow_spurious", {31'b0, overflow}, 32'd0);
      if (u_if.out_valid && u_if.out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_word: got %h, want no word", u_if.out_data);
        end else begin
          chk("stream_word", {16'b0, u_if.out_data}, {16'b0, exp_q.pop_front()});
        end
        got_q.push_back(u_if.out_data);
      end
      if (u_if.enc_read && u_if.enc_valid) begin
        xfer_cnt++;
        if (pending.size() != 0) void'(pending.pop_front());
      end
    end
  end

  task automatic drive_inputs();
    u_if.enc_valid = (pending.size() != 0);
    u_if.enc_addr  = (pending.size() != 0) ? pending[0] : 7'd0;
    u_if.out_ready = ($urandom_range(99) < rdy_pct);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drive_inputs();
  endtask

  task automatic do_reset(input bit clear_pending);
    reset       = 1'b1;
    frame_start = 1'b0;
    tick();
    reset = 1'b0;
    exp_q.delete();
    if (clear_pending) pending.delete();
    m_frame  = '0;
    m_missed = 1'b0;
    m_over   = 1'b0;
    drive_inputs();
  endtask

  // Expected frame: header, first min(N, MAX_HITS) pending hits, trailer.
  task automatic start_frame(output int leftover);
    int n;
    int m;
    n = pending.size();
    m = (n > int'(MAX_HITS)) ? int'(MAX_HITS) : n;
    leftover = n - m;
    exp_q.push_back({2'b10, m_frame + 14'd1});
    for (int i = 0; i < m; i++) exp_q.push_back({9'b0, pending[i]});
    exp_q.push_back({2'b11, 6'b0, 8'(m)});
    if (n > int'(MAX_HITS)) m_over = 1'b1;
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_frame = m_frame + 14'd1;
  endtask

  task automatic pulse_missed();
    frame_start = 1'b1;
    tick();
    frame_start = 1'b0;
    m_missed = 1'b1;
  endtask

  task automatic wait_drain(input int limit, input int leftover);
    for (int i = 0; i < limit && exp_q.size() != 0; i++) tick();
    chk("drain_words_left", exp_q.size(), 32'd0);
    exp_q.delete();
    tick();
    tick();
    chk("out_valid_after_frame", {31'b0, u_if.out_valid}, 32'd0);
    chk("overflow_after_frame", {31'b0, overflow}, {31'b0, m_over});
    chk("leftover_hits", pending.size(), leftover);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int left;
    reset       = 1'b1;
    frame_start = 1'b0;
    rdy_pct     = 100;
    drive_inputs();
    tick();
    do_reset(1'b1);

    // Reset state.
    chk("rst_out_valid", {31'b0, u_if.out_valid}, 32'd0);
    chk("rst_out_data", {16'b0, u_if.out_data}, 32'd0);
    chk("rst_enc_read", {31'b0, u_if.enc_read}, 32'd0);
    chk("rst_frame_cnt", {18'b0, frame_cnt}, 32'd0);
    chk("rst_flags", {30'b0, overflow, missed_frame}, 32'd0);

    // Empty frame.
    got_q.delete();
    xfer_cnt = 0;
    start_frame(left);
    wait_drain(200, left);
    chk("empty_len", got_q.size(), 32'd2);
    chk("empty_hdr", {16'b0, got_at(0)}, 32'h8001);
    chk("empty_trl", {16'b0, got_at(1)}, 32'hC000);
    chk("empty_xfers", xfer_cnt, 32'd0);
    chk("empty_frame_cnt", {18'b0, frame_cnt}, 32'd1);

    // Three hits.
    do_reset(1'b1);
    pending = '{7'd5, 7'd64, 7'd127};
    drive_inputs();
    got_q.delete();
    xfer_cnt = 0;
    start_frame(left);
    wait_drain(200, left);
    chk("three_len", got_q.size(), 32'd5);
    chk("three_w0", {16'b0, got_at(0)}, 32'h8001);
    chk("three_w1", {16'b0, got_at(1)}, 32'h0005);
    chk("three_w2", {16'b0, got_at(2)}, 32'h0040);
    chk("three_w3", {16'b0, got_at(3)}, 32'h007F);
    chk("three_w4", {16'b0, got_at(4)}, 32'hC003);
    chk("three_xfers", xfer_cnt, 32'd3);

    // Backpressure: FIFO fills with header + 15 hits, then reading stops.
    rdy_pct = 0;
    for (int i = 0; i < 20; i++) pending.push_back(7'(i * 3 + 1));
    drive_inputs();
    got_q.delete();
    xfer_cnt = 0;
    start_frame(left);
    repeat (40) tick();
    chk("bp_enc_read_low", {31'b0, u_if.enc_read}, 32'd0);
    chk("bp_xfers_at_full", xfer_cnt, 32'd15);
    chk("bp_out_valid", {31'b0, u_if.out_valid}, 32'd1);
    rdy_pct = 100;
    wait_drain(400, left);
    chk("bp_len", got_q.size(), 32'd22);
    chk("bp_hdr", {16'b0, got_at(0)}, 32'h8002);
    chk("bp_first_hit", {16'b0, got_at(1)}, 32'h0001);
    chk("bp_trl", {16'b0, got_at(21)}, 32'hC014);

    // Truncation: 200 hits pending, 128 taken.
    for (int i = 0; i < 200; i++) pending.push_back(7'($urandom_range(127)));
    rdy_pct = 70;
    drive_inputs();
    got_q.delete();
    start_frame(left);
    wait_drain(3000, left);
    chk("trunc_len", got_q.size(), 32'd130);
    chk("trunc_hdr", {16'b0, got_at(0)}, 32'h8003);
    chk("trunc_trl", {16'b0, got_at(129)}, 32'hC080);
    chk("trunc_overflow", {31'b0, overflow}, 32'd1);

    // frame_start during SCAN is ignored; 72 leftover hits fill this frame.
    got_q.delete();
    start_frame(left);
    tick();
    pulse_missed();
    wait_drain(2000, left);
    chk("missed_flag", {31'b0, missed_frame}, 32'd1);
    chk("missed_frame_cnt", {18'b0, frame_cnt}, 32'd4);
    chk("missed_hdr", {16'b0, got_at(0)}, 32'h8004);
    chk("missed_trl", {16'b0, got_at(73)}, 32'hC048);
    chk("overflow_sticky", {31'b0, overflow}, 32'd1);
    got_q.delete();
    start_frame(left);
    wait_drain(200, left);
    chk("next_hdr", {16'b0, got_at(0)}, 32'h8005);

    // Reset mid-SCAN with five words buffered; the encoder keeps its hits.
    rdy_pct = 0;
    for (int i = 0; i < 30; i++) pending.push_back(7'($urandom_range(127)));
    drive_inputs();
    start_frame(left);
    repeat (5) tick();
    chk("mid_out_valid", {31'b0, u_if.out_valid}, 32'd1);
    chk("mid_xfers_pending", pending.size(), 32'd26);
    do_reset(1'b0);
    chk("mid_rst_out_valid", {31'b0, u_if.out_valid}, 32'd0);
    chk("mid_rst_enc_read", {31'b0, u_if.enc_read}, 32'd0);
    chk("mid_rst_frame_cnt", {18'b0, frame_cnt}, 32'd0);
    chk("mid_rst_flags", {30'b0, overflow, missed_frame}, 32'd0);
    chk("mid_rst_pending", pending.size(), 32'd26);
    rdy_pct = 100;
    drive_inputs();
    got_q.delete();
    start_frame(left);
    wait_drain(400, left);
    chk("after_rst_hdr", {16'b0, got_at(0)}, 32'h8001);
    chk("after_rst_trl", {16'b0, got_at(27)}, 32'hC01A);

    // Randomized frames with random sink readiness.
    for (int f = 0; f < 30; f++) begin
      int n;
      case ($urandom_range(5))
        0:       n = 0;
        1:       n = 127;
        2:       n = 128;
        3:       n = 129 + $urandom_range(30);
        default: n = $urandom_range(1, 40);
      endcase
      case ($urandom_range(2))
        0:       rdy_pct = 100;
        1:       rdy_pct = 60;
        default: rdy_pct = 25;
      endcase
      for (int i = 0; i < n; i++) pending.push_back(7'($urandom_range(127)));
      drive_inputs();
      start_frame(left);
      if ($urandom_range(3) == 0) pulse_missed();
      wait_drain(6000, left);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
